// File: rtl/montgomery_pkg.sv
// Shared definitions for the parametrised bit-serial Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } mont_state_e;

  // Counter must reach N-1 without wrapping.
  function automatic int unsigned mont_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/montgomery_mult_param_step.sv
// One radix-2 Montgomery iteration: C_next = (C + a_i*B + q*M) >> 1, q = LSB of the partial sum.
module montgomery_step #(
  parameter int unsigned N = 512
) (
  input  logic [N+1:0] c,
  input  logic         a_bit,
  input  logic [N-1:0] b,
  input  logic [N-1:0] m,
  output logic [N+1:0] c_next
);

  logic [N+1:0] t;
  logic [N+1:0] u;

  // Two chained N+2-bit adders; kept separate from the FSM for later pipelining.
  always_comb begin
    t      = c + (a_bit ? {2'b00, b} : '0);
    u      = t + (t[0] ? {2'b00, m} : '0);
    c_next = u >> 1;
  end

endmodule

// File: rtl/montgomery_mult_param.sv
// Parametrised bit-serial Montgomery multiplier: result = A*B*2^-N mod M with final subtraction.
module montgomery_mult_param
  import montgomery_pkg::*;
#(
  parameter int unsigned N     = 512,
  parameter int unsigned CNT_W = mont_cnt_w(N)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         m_even_err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ITER = ITER;
  localparam logic [1:0] ST_SUB  = SUB;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [N-1:0]     a_reg;
  logic [N-1:0]     b_reg;
  logic [N-1:0]     m_reg;
  logic [N+1:0]     c_reg;
  logic [N+1:0]     c_next;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [N-1:0]     sub_val;

  montgomery_step #(.N(N)) u_step (
    .c      (c_reg),
    .a_bit  (a_reg[0]),
    .b      (b_reg),
    .m      (m_reg),
    .c_next (c_next)
  );

  // Low N bits of C-M equal the low N bits of the full N+2-bit difference.
  always_comb begin
    borrow  = c_reg < {2'b00, m_reg};
    sub_val = c_reg[N-1:0] - m_reg;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= '0;
      c_reg      <= '0;
      cnt        <= '0;
      result     <= '0;
      done       <= 1'b0;
      m_even_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            m_reg      <= in_m;
            c_reg      <= '0;
            cnt        <= '0;
            m_even_err <= ~in_m[0];
            state      <= ST_ITER;
          end
        end
        ST_ITER: begin
          c_reg <= c_next;
          a_reg <= {1'b0, a_reg[N-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          if (m_even_err) begin
            result <= '0;
          end else if (borrow) begin
            result <= c_reg[N-1:0];
          end else begin
            result <= sub_val;
          end
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Bench for montgomery_mult_param: small (N=8) directed instance and wide (N=512) random instance.
module tb_montgomery_mult_param;

  localparam int unsigned NS = 8;
  localparam int unsigned NL = 512;
  localparam int unsigned NRAND = 12;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          start_s = 1'b0;
  logic [NS-1:0] a_s = '0, b_s = '0, m_s = '0;
  logic [NS-1:0] res_s;
  logic          done_s, busy_s, err_s;

  logic          start_l = 1'b0;
  logic [NL-1:0] a_l = '0, b_l = '0, m_l = '0;
  logic [NL-1:0] res_l;
  logic          done_l, busy_l, err_l;

  montgomery_mult_param #(.N(NS)) u_small (
    .clk(clk), .resetn(resetn), .start(start_s),
    .in_a(a_s), .in_b(b_s), .in_m(m_s),
    .result(res_s), .done(done_s), .busy(busy_s), .m_even_err(err_s)
  );

  montgomery_mult_param #(.N(NL)) u_large (
    .clk(clk), .resetn(resetn), .start(start_l),
    .in_a(a_l), .in_b(b_l), .in_m(m_l),
    .result(res_l), .done(done_l), .busy(busy_l), .m_even_err(err_l)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [NL-1:0] act, input logic [NL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: find R with R*2^n == A*B (mod M) by multiplying with the inverse of 2 n times.
  function automatic logic [NL-1:0] mont_ref(input logic [NL-1:0] a, input logic [NL-1:0] b,
                                             input logic [NL-1:0] m, input int unsigned n);
    logic [2*NL-1:0] p, inv2, mm;
    if (m[0] == 1'b0) return '0;
    mm   = {{NL{1'b0}}, m};
    p    = ({{NL{1'b0}}, a} * {{NL{1'b0}}, b}) % mm;
    inv2 = (mm + 1) >> 1;
    for (int unsigned k = 0; k < n; k++) p = (p * inv2) % mm;
    return p[NL-1:0];
  endfunction

  // Transaction-level timing model: age counts edges since the accepting edge.
  typedef struct {
    int unsigned   age;
    logic [NL-1:0] pend;
    logic [NL-1:0] res;
    logic          err;
    logic          dn;
    logic          bsy;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t s, input logic rst_n, input logic st,
                                    input logic [NL-1:0] a, input logic [NL-1:0] b,
                                    input logic [NL-1:0] m, input int unsigned n);
    mdl_t r = s;
    if (!rst_n) begin
      r.age = 0; r.res = '0; r.err = 1'b0; r.dn = 1'b0; r.bsy = 1'b0;
      return r;
    end
    r.dn = 1'b0;
    if (s.age == 0) begin
      if (st) begin
        r.age  = 1;
        r.err  = ~m[0];
        r.pend = mont_ref(a, b, m, n);
        r.bsy  = 1'b1;
      end
    end else begin
      r.age = s.age + 1;
      if (r.age == n + 2) begin
        r.res = r.pend;
        r.dn  = 1'b1;
      end
      if (r.age == n + 3) begin
        r.age = 0;
        r.bsy = 1'b0;
      end
    end
    return r;
  endfunction

  mdl_t ms = '{age: 0, pend: '0, res: '0, err: 1'b0, dn: 1'b0, bsy: 1'b0};
  mdl_t ml = '{age: 0, pend: '0, res: '0, err: 1'b0, dn: 1'b0, bsy: 1'b0};

  always @(posedge clk) begin
    ms <= mdl_step(ms, resetn, start_s, NL'(a_s), NL'(b_s), NL'(m_s), NS);
    ml <= mdl_step(ml, resetn, start_l, a_l, b_l, m_l, NL);
  end

  always @(negedge clk) begin
    chk("small_done", NL'(done_s), NL'(ms.dn));
    chk("small_busy", NL'(busy_s), NL'(ms.bsy));
    chk("small_err",  NL'(err_s),  NL'(ms.err));
    chk("small_res",  NL'(res_s),  NL'(ms.res[NS-1:0]));
    chk("large_done", NL'(done_l), NL'(ml.dn));
    chk("large_busy", NL'(busy_l), NL'(ml.bsy));
    chk("large_err",  NL'(err_l),  NL'(ml.err));
    chk("large_res",  res_l,       ml.res);
  end

  // One N=8 operation; poke=1 also pulses start during busy and in the DONE cycle.
  task automatic run_s(input string nm, input logic [NS-1:0] a, input logic [NS-1:0] b,
                       input logic [NS-1:0] m, input logic [NS-1:0] want,
                       input logic want_err, input bit poke);
    int unsigned cyc;
    int unsigned extra;
    @(posedge clk); #1;
    a_s = a; b_s = b; m_s = m; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    a_s = ~a; b_s = ~b; m_s = ~m;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done_s) break;
      if (poke) start_s = (cyc == 3 || cyc == 6);
    end
    chk({nm, "_latency"}, NL'(cyc), NL'(10));
    chk({nm, "_result"}, NL'(res_s), NL'(want));
    chk({nm, "_err"}, NL'(err_s), NL'(want_err));
    if (poke) begin
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_s) extra++;
      end
      chk({nm, "_extra_done"}, NL'(extra), NL'(0));
    end
  endtask

  task automatic rand_wide(output logic [NL-1:0] v);
    for (int unsigned j = 0; j < NL / 32; j++) v[j*32 +: 32] = $urandom;
  endtask

  task automatic run_large_batch();
    logic [NL-1:0] rm, ra, rb;
    time           prev;
    int unsigned   cyc;
    prev = 0;
    rand_wide(rm); rm[0] = 1'b1; rm[NL-1] = 1'b1;
    rand_wide(ra); rand_wide(rb);
    @(posedge clk); #1;
    m_l = rm; a_l = ra % rm; b_l = rb % rm; start_l = 1'b1;
    for (int unsigned k = 0; k < NRAND; k++) begin
      @(posedge clk); #1;
      start_l = 1'b0;
      cyc = 0;
      while (cyc < 600) begin
        @(negedge clk);
        cyc++;
        if (done_l) break;
      end
      chk("large_latency", NL'(cyc), NL'(NL + 2));
      if (k > 0) chk("large_interval", NL'(($time - prev) / 10), NL'(NL + 3));
      prev = $time;
      if (k < NRAND - 1) begin
        rand_wide(rm); rm[0] = 1'b1; rm[NL-1] = 1'b1;
        rand_wide(ra); rand_wide(rb);
        @(posedge clk); #1;
        m_l = rm; a_l = ra % rm; b_l = rb % rm; start_l = 1'b1;
      end
    end
  endtask

  initial begin
    int unsigned extra;
    chk("pin_5x7",   mont_ref(5, 7, 13, NS),   NL'(1));
    chk("pin_1x1",   mont_ref(1, 1, 13, NS),   NL'(3));
    chk("pin_12x12", mont_ref(12, 12, 13, NS), NL'(3));
    chk("pin_0x9",   mont_ref(0, 9, 13, NS),   NL'(0));

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    run_s("basic",   8'd5,  8'd7,  8'd13, 8'd1, 1'b0, 1'b0);
    run_s("one",     8'd1,  8'd1,  8'd13, 8'd3, 1'b0, 1'b0);
    run_s("max",     8'd12, 8'd12, 8'd13, 8'd3, 1'b0, 1'b0);
    run_s("zero",    8'd0,  8'd9,  8'd13, 8'd0, 1'b0, 1'b1);
    run_s("even",    8'd5,  8'd7,  8'd12, 8'd0, 1'b1, 1'b0);
    run_s("clear",   8'd5,  8'd7,  8'd13, 8'd1, 1'b0, 1'b0);
    run_s("even2",   8'd5,  8'd7,  8'd12, 8'd0, 1'b1, 1'b0);
    run_s("restore", 8'd5,  8'd7,  8'd13, 8'd1, 1'b0, 1'b0);

    // Abort an operation mid-iteration while result and err are nonzero-able.
    run_s("pre_abort", 8'd3, 8'd9, 8'd13, 8'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_s = 8'd3; b_s = 8'd4; m_s = 8'd12; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_result", NL'(res_s), NL'(0));
    chk("abort_busy",   NL'(busy_s), NL'(0));
    chk("abort_err",    NL'(err_s), NL'(0));
    resetn = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s) extra++;
    end
    chk("abort_no_done", NL'(extra), NL'(0));
    run_s("after_abort", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, 1'b0);

    run_large_batch();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
